// File: rtl/tetris_pkg.sv
// Shared tetris definitions: board geometry, collision-check FSM states and
// a cell-bounds helper used by the shape, board and collision-check blocks.
// No ports; import with tetris_pkg::*.
package tetris_pkg;

   localparam int BOARD_W = 10;   // board width in cells (one bit per cell in a row word)
   localparam int BOARD_H = 20;   // board height in rows
   localparam int CELLS   = 4;    // cells per tetromino
   localparam int COORD_W = 5;    // width of each x/y coordinate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CHK  = 2'd2,
      DONE = 2'd3
   } chk_state_e;

   // True when a cell lies outside a w x h board. Coordinates are unsigned,
   // so values that wrapped in upstream adders land here as large numbers.
   function automatic logic cell_oob(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y,
                                     input int                 w,
                                     input int                 h);
      return (int'(x) >= w) || (int'(y) >= h);
   endfunction

endpackage

// File: rtl/piece_collision_check.sv
// Purpose : checks the four cells of a candidate tetromino placement against
//           the board bounds and the board occupancy, one cell at a time.
// Latency : start in cycle 0 -> done in cycle 9 when free; 2i+3 on an occupied
//           cell i, 2i+2 on an out-of-bounds cell i.
// Backpressure: none; start is ignored while busy_o is high.
// Ports   : clk/rst (async active-high), start_i, xpos_i/ypos_i (4 x 5-bit cell
//           coordinates), row_rd_o/row_addr_o board read request, row_data_i
//           (valid one cycle after row_rd_o), busy_o, done_o (1-cycle pulse),
//           collide_o (held until the next accepted start).
module piece_collision_check #(
   parameter int BOARD_W = tetris_pkg::BOARD_W,
   parameter int BOARD_H = tetris_pkg::BOARD_H
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [3:0][4:0]     xpos_i,
   input  logic [3:0][4:0]     ypos_i,
   output logic                row_rd_o,
   output logic [4:0]          row_addr_o,
   input  logic [BOARD_W-1:0]  row_data_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                collide_o
);
   import tetris_pkg::*;

   chk_state_e         state_q;
   logic [1:0]         idx_q;
   logic               collide_q;
   logic [3:0][4:0]    x_q;
   logic [3:0][4:0]    y_q;

   logic [4:0]         x_cur;
   logic [4:0]         y_cur;
   logic               cur_oob;
   logic [BOARD_W-1:0] row_shifted;
   logic               cur_hit;

   assign x_cur   = x_q[idx_q];
   assign y_cur   = y_q[idx_q];
   assign cur_oob = cell_oob(x_cur, y_cur, BOARD_W, BOARD_H);

   // Shift rather than index: x_cur is wider than a BOARD_W bit index, and in
   // CHK it is already known to be in range.
   assign row_shifted = row_data_i >> x_cur;
   assign cur_hit     = row_shifted[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= 2'd0;
         collide_q <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  x_q       <= xpos_i;
                  y_q       <= ypos_i;
                  collide_q <= 1'b0;
                  idx_q     <= 2'd0;
                  state_q   <= REQ;
               end else begin
                  state_q   <= IDLE;
               end
            end
            REQ: begin
               if (cur_oob) begin
                  collide_q <= 1'b1;
                  state_q   <= DONE;
               end else begin
                  state_q   <= CHK;
               end
            end
            CHK: begin
               if (cur_hit) begin
                  collide_q <= 1'b1;
                  state_q   <= DONE;
               end else if (idx_q == 2'd3) begin
                  state_q   <= DONE;
               end else begin
                  idx_q     <= idx_q + 2'd1;
                  state_q   <= REQ;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Outputs are pure decodes of registered state; the read is suppressed for
   // an out-of-bounds cell so the board is never addressed past its last row.
   assign busy_o     = (state_q == REQ) || (state_q == CHK);
   assign done_o     = (state_q == DONE);
   assign row_rd_o   = (state_q == REQ) && !cur_oob;
   assign row_addr_o = y_cur;
   assign collide_o  = collide_q;

endmodule
